// File: rtl/wts_pkg.sv
// Shared types and constants for the WTS channel scheduler and its config register file.
package wts_pkg;

    localparam int NUM_CH = 5;
    localparam int FREQ_W = 12;

    typedef logic [2:0] wts_slot_t;

    typedef enum logic [1:0] {
        SEL_FREQ_LO = 2'd0,
        SEL_FREQ_HI = 2'd1,
        SEL_WLEN    = 2'd2,
        SEL_CTRL    = 2'd3
    } wts_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMMIT    = 2'd1,
        ST_WAIT_SLOT = 2'd2
    } wts_state_e;

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [1:0]        wave_length;
        logic              wave_reset;
    } wts_ch_cfg_t;

endpackage

// File: rtl/wts_channel_config_regs.sv
// Per-channel tone configuration plus low-byte frequency staging; one write port,
// one read port for the active slot and a wave-reset tap for the channel being written.
module wts_channel_config_regs
    import wts_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  wts_slot_t   wr_ch_i,
    input  wts_sel_e    wr_sel_i,
    input  logic [7:0]  wr_data_i,
    input  wts_slot_t   rd_slot_i,
    output wts_ch_cfg_t rd_cfg_o,
    output logic        wr_wave_reset_o
);

    wts_ch_cfg_t       cfg_q      [NUM_CH];
    logic [7:0]        stage_lo_q [NUM_CH];
    logic [NUM_CH-1:0] hit;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_hit
            assign hit[gi] = we_i && (wr_ch_i == wts_slot_t'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                cfg_q[i]      <= '0;
                stage_lo_q[i] <= '0;
            end else if (hit[i]) begin
                case (wr_sel_i)
                    SEL_FREQ_LO: stage_lo_q[i]        <= wr_data_i;
                    SEL_FREQ_HI: cfg_q[i].freq        <= {wr_data_i[3:0], stage_lo_q[i]};
                    SEL_WLEN:    cfg_q[i].wave_length <= wr_data_i[1:0];
                    SEL_CTRL:    cfg_q[i].wave_reset  <= wr_data_i[0];
                    default:     ;
                endcase
            end
        end
    end

    // Slot indices above NUM_CH-1 read as all-zero rather than aliasing a channel.
    always_comb begin
        rd_cfg_o        = '0;
        wr_wave_reset_o = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_slot_i == wts_slot_t'(i)) rd_cfg_o = cfg_q[i];
            if (wr_ch_i == wts_slot_t'(i))   wr_wave_reset_o = cfg_q[i].wave_reset;
        end
    end

endmodule

// File: rtl/wts_channel_scheduler.sv
// Slot rotation and CPU write sequencer in front of the 5-channel tone generator:
// one write at a time, committed to the config file, with counter-clear and wave-restart pulses.
module wts_channel_scheduler
    import wts_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        bus_wr,
    input  logic [2:0]  bus_ch,
    input  logic [1:0]  bus_sel,
    input  logic [7:0]  bus_wdata,
    output logic        bus_ready,
    output logic [2:0]  active,
    output logic        address_reset,
    output logic [11:0] reg_frequency_count,
    output logic [1:0]  reg_wave_length,
    output logic        reg_wave_reset,
    output logic        clear_counter_a,
    output logic        clear_counter_b,
    output logic        clear_counter_c,
    output logic        clear_counter_d,
    output logic        clear_counter_e
);

    wts_state_e        state_q, state_d;
    wts_slot_t         active_q, ch_q;
    wts_sel_e          sel_q;
    logic [7:0]        data_q;
    logic              bus_ready_q;
    logic              accept, ch_valid, commit_we, addr_pulse, wr_wave_reset;
    logic [NUM_CH-1:0] clear_vec;
    wts_ch_cfg_t       rd_cfg;

    assign accept   = bus_wr && bus_ready_q;
    assign ch_valid = (ch_q < wts_slot_t'(NUM_CH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            active_q    <= '0;
            ch_q        <= '0;
            sel_q       <= SEL_FREQ_LO;
            data_q      <= '0;
            bus_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_ready_q <= (state_d == ST_IDLE);
            if (enable) active_q <= (active_q == wts_slot_t'(NUM_CH - 1)) ? '0 : active_q + 3'd1;
            if (accept) begin
                ch_q   <= bus_ch;
                sel_q  <= wts_sel_e'(bus_sel);
                data_q <= bus_wdata;
            end
        end
    end

    // Writes to a nonexistent channel still walk through COMMIT so the handshake
    // timing is identical, but they never touch the register file or wait for a slot.
    always_comb begin
        state_d    = state_q;
        commit_we  = 1'b0;
        addr_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                commit_we = ch_valid;
                state_d   = (sel_q == SEL_CTRL && data_q[1] && ch_valid) ? ST_WAIT_SLOT : ST_IDLE;
            end
            ST_WAIT_SLOT: begin
                if (active_q == ch_q) begin
                    addr_pulse = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    wts_channel_config_regs u_cfg (
        .clk             (clk),
        .reset           (reset),
        .we_i            (commit_we),
        .wr_ch_i         (ch_q),
        .wr_sel_i        (sel_q),
        .wr_data_i       (data_q),
        .rd_slot_i       (active_q),
        .rd_cfg_o        (rd_cfg),
        .wr_wave_reset_o (wr_wave_reset)
    );

    // A high-byte commit leaves wave_reset untouched, so the current flag is the post-commit value.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_clear
            assign clear_vec[gi] = !reset && commit_we && (sel_q == SEL_FREQ_HI)
                                   && (ch_q == wts_slot_t'(gi)) && wr_wave_reset;
        end
    endgenerate

    assign bus_ready           = bus_ready_q;
    assign active              = active_q;
    assign address_reset       = addr_pulse && !reset;
    assign reg_frequency_count = rd_cfg.freq;
    assign reg_wave_length     = rd_cfg.wave_length;
    assign reg_wave_reset      = rd_cfg.wave_reset;
    assign clear_counter_a     = clear_vec[0];
    assign clear_counter_b     = clear_vec[1];
    assign clear_counter_c     = clear_vec[2];
    assign clear_counter_d     = clear_vec[3];
    assign clear_counter_e     = clear_vec[4];

endmodule

// File: tb/tb_wts_channel_scheduler.sv
// Directed bench for wts_channel_scheduler: expected pulses are queued when a write is
// issued and matched by a negedge monitor; static outputs are asserted inline.
module tb_wts_channel_scheduler;

    logic        clk = 1'b0;
    logic        reset, enable, bus_wr;
    logic [2:0]  bus_ch;
    logic [1:0]  bus_sel;
    logic [7:0]  bus_wdata;
    logic        bus_ready, address_reset, reg_wave_reset;
    logic [2:0]  active;
    logic [11:0] reg_frequency_count;
    logic [1:0]  reg_wave_length;
    logic        clr_a, clr_b, clr_c, clr_d, clr_e;
    logic [4:0]  clr;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       is_addr;
        logic [2:0] ch;
    } pulse_t;
    pulse_t sb[$];

    wts_channel_scheduler dut (
        .clk                 (clk),
        .reset               (reset),
        .enable              (enable),
        .bus_wr              (bus_wr),
        .bus_ch              (bus_ch),
        .bus_sel             (bus_sel),
        .bus_wdata           (bus_wdata),
        .bus_ready           (bus_ready),
        .active              (active),
        .address_reset       (address_reset),
        .reg_frequency_count (reg_frequency_count),
        .reg_wave_length     (reg_wave_length),
        .reg_wave_reset      (reg_wave_reset),
        .clear_counter_a     (clr_a),
        .clear_counter_b     (clr_b),
        .clear_counter_c     (clr_c),
        .clear_counter_d     (clr_d),
        .clear_counter_e     (clr_e)
    );

    assign clr = {clr_e, clr_d, clr_c, clr_b, clr_a};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_active(input logic [2:0] target);
        int n = 0;
        while (active !== target && n < 20) begin
            tick();
            n++;
        end
        check("wait_active", {29'd0, active}, {29'd0, target});
    endtask

    task automatic do_write(input logic [2:0] ch, input logic [1:0] sel, input logic [7:0] d);
        int n = 0;
        while (bus_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("ready_wait", {31'd0, bus_ready}, 32'd1);
        bus_wr = 1'b1; bus_ch = ch; bus_sel = sel; bus_wdata = d;
        tick();
        bus_wr = 1'b0;
        $display("write ch=%0d sel=%0d data=%02h accepted, active=%0d", ch, sel, d, active);
    endtask

    // Every pulse must match the oldest queued expectation; stray pulses are failures.
    always @(negedge clk) begin
        if (address_reset || (clr != 5'd0)) begin
            pulse_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_pulse: observed addr=%0b clr=%05b expected none", address_reset, clr);
            end else begin
                e = sb.pop_front();
                check("pulse_vec", {26'd0, address_reset, clr},
                      {26'd0, e.is_addr, (e.is_addr ? 5'd0 : (5'd1 << e.ch))});
                if (e.is_addr) check("pulse_slot", {29'd0, active}, {29'd0, e.ch});
                $display("pulse addr=%0b clr=%05b active=%0d", address_reset, clr, active);
            end
        end
    end

    initial begin
        logic exp_ready;
        reset = 1'b1; enable = 1'b0; bus_wr = 1'b0;
        bus_ch = '0; bus_sel = '0; bus_wdata = '0;
        tick(); tick();

        // Reset state
        check("rst_active", {29'd0, active}, 32'd0);
        check("rst_ready", {31'd0, bus_ready}, 32'd0);
        check("rst_freq", {20'd0, reg_frequency_count}, 32'd0);
        check("rst_wlen", {30'd0, reg_wave_length}, 32'd0);
        check("rst_wres", {31'd0, reg_wave_reset}, 32'd0);
        check("rst_pulses", {26'd0, address_reset, clr}, 32'd0);

        // 1: slot rotation
        reset = 1'b0; enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("rot_active", {29'd0, active}, (i + 1) % 5);
            check("rot_cfg", {17'd0, reg_frequency_count, reg_wave_length, reg_wave_reset}, 32'd0);
        end
        check("ready_after_rst", {31'd0, bus_ready}, 32'd1);

        // 2: staged frequency write on channel C with wave_reset set
        do_write(3'd2, 2'd0, 8'h34);
        tick();
        wait_active(3'd2);
        check("lo_only_freq", {20'd0, reg_frequency_count}, 32'd0);
        do_write(3'd2, 2'd3, 8'h01);
        sb.push_back('{is_addr: 1'b0, ch: 3'd2});
        do_write(3'd2, 2'd1, 8'h02);
        wait_active(3'd2);
        check("c_freq", {20'd0, reg_frequency_count}, 32'h234);
        check("c_wres", {31'd0, reg_wave_reset}, 32'd1);
        wait_active(3'd3);
        check("d_freq", {20'd0, reg_frequency_count}, 32'd0);

        // 3: wave restart on channel E requested while slot 1 is active
        wait_active(3'd1);
        enable = 1'b0;
        sb.push_back('{is_addr: 1'b1, ch: 3'd4});
        do_write(3'd4, 2'd3, 8'h03);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("ws_hold_ready", {31'd0, bus_ready}, 32'd0);
            check("ws_hold_active", {29'd0, active}, 32'd1);
            check("ws_hold_addr", {31'd0, address_reset}, 32'd0);
        end
        enable = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("ws_active", {29'd0, active}, i);
            check("ws_ready", {31'd0, bus_ready}, 32'd0);
            check("ws_addr", {31'd0, address_reset}, (i == 4) ? 32'd1 : 32'd0);
        end
        check("e_wres", {31'd0, reg_wave_reset}, 32'd1);
        tick();
        check("ws_ready_back", {31'd0, bus_ready}, 32'd1);
        check("ws_addr_done", {31'd0, address_reset}, 32'd0);

        // 4: bus_wr held high; accepts alternate with the COMMIT cycle
        exp_ready = 1'b1;
        bus_wr = 1'b1; bus_ch = 3'd5; bus_sel = 2'd1; bus_wdata = 8'hFF;
        for (int i = 0; i < 18; i++) begin
            check("held_ready", {31'd0, bus_ready}, {31'd0, exp_ready});
            if (i == 6)  begin bus_sel = 2'd3; bus_wdata = 8'h03; end
            if (i == 12) begin bus_ch = 3'd1; bus_sel = 2'd2; bus_wdata = 8'h02; end
            exp_ready = !exp_ready;
            tick();
        end
        bus_wr = 1'b0;
        tick(); tick();
        wait_active(3'd1);
        check("b_wlen", {30'd0, reg_wave_length}, 32'd2);
        wait_active(3'd2);
        check("c_freq_kept", {20'd0, reg_frequency_count}, 32'h234);
        check("c_wlen_kept", {30'd0, reg_wave_length}, 32'd0);
        wait_active(3'd4);
        check("e_freq_kept", {20'd0, reg_frequency_count}, 32'd0);
        check("e_wres_kept", {31'd0, reg_wave_reset}, 32'd1);

        // 5: reset while waiting for slot D
        wait_active(3'd0);
        enable = 1'b0;
        do_write(3'd3, 2'd3, 8'h02);
        tick();
        check("r5_ready", {31'd0, bus_ready}, 32'd0);
        reset = 1'b1; enable = 1'b1;
        tick();
        check("r5_active", {29'd0, active}, 32'd0);
        check("r5_ready_rst", {31'd0, bus_ready}, 32'd0);
        reset = 1'b0;
        wait_active(3'd2);
        check("r5_c_freq", {20'd0, reg_frequency_count}, 32'd0);
        check("r5_c_wres", {31'd0, reg_wave_reset}, 32'd0);
        wait_active(3'd3);
        wait_active(3'd4);
        check("r5_e_wres", {31'd0, reg_wave_reset}, 32'd0);
        check("r5_ready_back", {31'd0, bus_ready}, 32'd1);
        tick(); tick();

        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
